// File: rtl/pipe_stall_ctrl_pkg.sv
// pipe_stall_ctrl_pkg
//   Shared definitions for the pipeline stall/flush controller:
//   stall-vector bit indices, per-requester stall patterns, FSM state
//   encoding and the requester priority encoder.
package pipe_stall_ctrl_pkg;

  // Stall-vector bit positions: {wb,mem,ex,id,if,pc}
  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  // A requester holds its own stage and every stage upstream of it.
  localparam logic [5:0] STALL_NONE    = 6'b000000;
  localparam logic [5:0] STALL_IF_REQ  = 6'b000011;
  localparam logic [5:0] STALL_ID_REQ  = 6'b000111;
  localparam logic [5:0] STALL_EX_REQ  = 6'b001111;
  localparam logic [5:0] STALL_MEM_REQ = 6'b011111;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_PEND  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  // The most downstream requester wins; its pattern covers all upstream ones.
  function automatic logic [5:0] prio_stall(input logic if_req,
                                            input logic id_req,
                                            input logic ex_req,
                                            input logic mem_req);
    if (mem_req)     return STALL_MEM_REQ;
    else if (ex_req) return STALL_EX_REQ;
    else if (id_req) return STALL_ID_REQ;
    else if (if_req) return STALL_IF_REQ;
    else             return STALL_NONE;
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_wdog.sv
// stall_wdog
//   Consecutive-stall watchdog. Counts back-to-back cycles with the PC
//   held, saturating at LIMIT; timeout_o sets on the edge the count
//   reaches LIMIT and stays set until reset.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   stall_i    PC-stage hold bit for the current cycle
//   clear_i    force the run-length count back to zero (flush cycle)
//   timeout_o  sticky watchdog flag
module stall_wdog #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic stall_i,
  input  logic clear_i,
  output logic timeout_o
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || !stall_i) cnt_d = '0;
    else if (cnt_q != LIM)   cnt_d = cnt_q + 1'b1;
    timeout_d = timeout_q | (cnt_d == LIM);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl
//   Central stall/flush controller for the 5-stage pipeline. Merges the
//   per-stage stall requests into a {wb,mem,ex,id,if,pc} hold vector,
//   sequences exception/ERET flushes (deferring them while a bus
//   transaction is outstanding) and counts stalled cycles.
//   Optional consecutive-stall watchdog: define PIPE_STALL_WDOG_EN.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   if/id/ex/mem_stallreq    per-stage stall requests
//   mem_busy                 bus transaction that must finish before a flush
//   excp_req, excp_pc        flush request (held until excp_ack) and target PC
//   stall                    per-stage hold bits
//   flush, flush_pc          one-cycle flush of all stages and the new PC
//   excp_ack                 one-cycle acceptance pulse (same cycle as flush)
//   stall_cycles             free-running count of cycles with stall[0]=1
//   stall_timeout            watchdog flag, 0 when the watchdog is not built
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_RUN   | normal operation, stall follows the requesters
// ST_PEND  | flush captured, waiting for mem_busy to drop; WB drains
// ST_FLUSH | single flush cycle, excp_ack pulses, nothing held
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int CNT_W       = 32,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_stallreq,
  input  logic              id_stallreq,
  input  logic              ex_stallreq,
  input  logic              mem_stallreq,
  input  logic              mem_busy,
  input  logic              excp_req,
  input  logic [ADDR_W-1:0] excp_pc,
  output logic [5:0]        stall,
  output logic              flush,
  output logic [ADDR_W-1:0] flush_pc,
  output logic              excp_ack,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic              stall_timeout
);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] flush_pc_q, flush_pc_d;
  logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
  logic [5:0]        stall_d;

  always_comb begin
    state_d    = state_q;
    flush_pc_d = flush_pc_q;
    stall_d    = STALL_NONE;
    case (state_q)
      ST_RUN: begin
        stall_d = prio_stall(if_stallreq, id_stallreq, ex_stallreq, mem_stallreq);
        // excp_req decides the transition; stall still reflects this cycle's requests.
        if (excp_req) begin
          flush_pc_d = excp_pc;
          state_d    = mem_busy ? ST_PEND : ST_FLUSH;
        end
      end
      ST_PEND: begin
        stall_d = STALL_MEM_REQ;
        if (!mem_busy) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        stall_d = STALL_NONE;
        state_d = ST_RUN;
      end
      default: begin
        stall_d = STALL_NONE;
        state_d = ST_RUN;
      end
    endcase
  end

  // Reset must hold the stall vector low even while requesters are active.
  assign stall = rst ? STALL_NONE : stall_d;

  assign stall_cycles_d = stall_cycles_q + CNT_W'(stall_d[STALL_PC]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_RUN;
      flush_pc_q     <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      flush_pc_q     <= flush_pc_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign flush        = (state_q == ST_FLUSH) && !rst;
  assign excp_ack     = flush;
  assign flush_pc     = flush_pc_q;
  assign stall_cycles = stall_cycles_q;

`ifdef PIPE_STALL_WDOG_EN
  stall_wdog #(
    .LIMIT(WDOG_CYCLES)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .stall_i  (stall_d[STALL_PC]),
    .clear_i  (state_q == ST_FLUSH),
    .timeout_o(stall_timeout)
  );
`else
  logic [31:0] wdog_limit_unused;
  assign wdog_limit_unused = WDOG_CYCLES;
  assign stall_timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
module tb_pipe_stall_ctrl;

  localparam int AW = 32;
  localparam int CW = 32;
  localparam int WD = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_stallreq = 1'b1, id_stallreq = 1'b1;
  logic          ex_stallreq = 1'b1, mem_stallreq = 1'b1;
  logic          mem_busy = 1'b1, excp_req = 1'b0;
  logic [AW-1:0] excp_pc = '0;
  logic [5:0]    stall;
  logic          flush, excp_ack, stall_timeout;
  logic [AW-1:0] flush_pc;
  logic [CW-1:0] stall_cycles;

  int errors = 0;
  int checks = 0;

  pipe_stall_ctrl #(.ADDR_W(AW), .CNT_W(CW), .WDOG_CYCLES(WD)) dut (
    .clk(clk), .rst(rst),
    .if_stallreq(if_stallreq), .id_stallreq(id_stallreq),
    .ex_stallreq(ex_stallreq), .mem_stallreq(mem_stallreq),
    .mem_busy(mem_busy), .excp_req(excp_req), .excp_pc(excp_pc),
    .stall(stall), .flush(flush), .flush_pc(flush_pc), .excp_ack(excp_ack),
    .stall_cycles(stall_cycles), .stall_timeout(stall_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_waiting;   // flush accepted but blocked by the bus
  bit          m_flushing;  // this cycle is the flush cycle
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  int          m_run;       // consecutive stalled cycles
  bit          m_to;

  function automatic logic [5:0] exp_stall();
    int level;
    if (rst || m_flushing) return 6'd0;
    if (m_waiting) return 6'b011111;
    level = mem_stallreq ? 4 : ex_stallreq ? 3 : id_stallreq ? 2 : if_stallreq ? 1 : 0;
    if (level == 0) return 6'd0;
    return 6'((1 << (level + 1)) - 1);
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [5:0] es;
    if (rst) begin
      m_waiting = 0; m_flushing = 0; m_pc = '0; m_cnt = '0; m_run = 0; m_to = 0;
    end else begin
      es = exp_stall();
      if (es[0]) m_cnt = m_cnt + 1;
      if (!es[0]) m_run = 0;
      else if (m_run < WD) m_run++;
      if (m_run == WD) m_to = 1;
      if (m_flushing) m_flushing = 0;
      else if (m_waiting) begin
        if (!mem_busy) begin m_waiting = 0; m_flushing = 1; end
      end else if (excp_req) begin
        m_pc = excp_pc;
        if (mem_busy) m_waiting = 1; else m_flushing = 1;
      end
    end
  end

  always @(negedge clk) begin
    bit ef;
    ef = !rst && m_flushing;
    check("stall", 64'(stall), 64'(exp_stall()));
    check("flush", 64'(flush), 64'(ef));
    check("excp_ack", 64'(excp_ack), 64'(ef));
    check("flush_pc", 64'(flush_pc), 64'(m_pc));
    check("stall_cycles", 64'(stall_cycles), 64'(m_cnt));
`ifdef PIPE_STALL_WDOG_EN
    check("stall_timeout", 64'(stall_timeout), 64'(m_to));
`else
    check("stall_timeout", 64'(stall_timeout), 64'(0));
`endif
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic i_if, input logic i_id, input logic i_ex, input logic i_mem);
    if_stallreq = i_if; id_stallreq = i_id; ex_stallreq = i_ex; mem_stallreq = i_mem;
  endtask

`ifdef PIPE_STALL_WDOG_EN
  localparam logic EXP_TO = 1'b1;
`else
  localparam logic EXP_TO = 1'b0;
`endif

  logic [5:0] vec [12] = '{6'b000000, 6'b100000, 6'b010000, 6'b001000, 6'b000100,
                          6'b000011, 6'b000001, 6'b110010, 6'b000000, 6'b011011,
                          6'b000001, 6'b101000};

  initial begin
    // reset with every request active
    #3;
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_flush", 64'(flush), 64'd0);
    check("rst_cycles", 64'(stall_cycles), 64'd0);
    step();
    rst = 0; mem_busy = 0; set_req(0, 0, 1, 0);
    #2;
    check("ex_stall", 64'(stall), 64'h0f);
    step(); #1;
    check("cycles_after_one", 64'(stall_cycles), 64'd1);

    // priority and same-cycle response
    step(); set_req(0, 1, 0, 1); #2;
    check("id_mem_stall", 64'(stall), 64'h1f);
    mem_stallreq = 0; #1;
    check("id_only_stall", 64'(stall), 64'h07);

    // exception without bus activity
    step(); set_req(0, 0, 0, 0); excp_req = 1; excp_pc = 32'hBFC00380; mem_busy = 0; #2;
    check("run_no_flush", 64'(flush), 64'd0);
    step(); if_stallreq = 1; #2;
    check("flush1", 64'(flush), 64'd1);
    check("ack1", 64'(excp_ack), 64'd1);
    check("flush_pc1", 64'(flush_pc), 64'hBFC00380);
    check("flush_stall1", 64'(stall), 64'd0);
    step(); excp_req = 0; if_stallreq = 0; #2;
    check("flush_done", 64'(flush), 64'd0);

    // exception deferred by mem_busy, PC change ignored
    step(); excp_req = 1; excp_pc = 32'hBFC00380; mem_busy = 1; #2;
    step(); excp_pc = 32'h0; #2;
    check("pend_stall1", 64'(stall), 64'h1f);
    step(); #2;
    check("pend_stall2", 64'(stall), 64'h1f);
    step(); mem_busy = 0; #2;
    check("pend_stall3", 64'(stall), 64'h1f);
    check("pend_no_flush", 64'(flush), 64'd0);
    step(); #2;
    check("flush2", 64'(flush), 64'd1);
    check("flush_pc2", 64'(flush_pc), 64'hBFC00380);
    step(); excp_req = 0; #2;
    check("flush2_done", 64'(flush), 64'd0);

    // reset while pending
    excp_req = 1; excp_pc = 32'h12345678; mem_busy = 1;
    step(); #2;
    check("pend_again", 64'(stall), 64'h1f);
    rst = 1; #1;
    check("rst_pend_stall", 64'(stall), 64'd0);
    check("rst_pend_pc", 64'(flush_pc), 64'd0);
    check("rst_pend_cycles", 64'(stall_cycles), 64'd0);
    step(); rst = 0; excp_req = 0; mem_busy = 0;
    step(); #2;
    check("post_rst_no_flush", 64'(flush), 64'd0);

    // watchdog: 8 consecutive stalled cycles
    if_stallreq = 1;
    for (int i = 0; i < 8; i++) step();
    #1;
    check("wdog_cycles8", 64'(stall_cycles), 64'd8);
    check("wdog_timeout", 64'(stall_timeout), 64'(EXP_TO));
    if_stallreq = 0;
    step(); step(); #1;
    check("wdog_sticky", 64'(stall_timeout), 64'(EXP_TO));

    // two 7-cycle runs separated by a gap never time out
    rst = 1; #2; rst = 0;
    step(); if_stallreq = 1;
    for (int i = 0; i < 7; i++) step();
    if_stallreq = 0; step(); step();
    if_stallreq = 1;
    for (int i = 0; i < 7; i++) step();
    if_stallreq = 0; step(); #1;
    check("wdog_no_timeout", 64'(stall_timeout), 64'd0);
    check("wdog_cycles14", 64'(stall_cycles), 64'd14);

    // mixed vectors {excp,busy,mem,ex,id,if}, checked every cycle by the model
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 12; i++) begin
        excp_req = vec[i][5]; mem_busy = vec[i][4];
        set_req(vec[i][0], vec[i][1], vec[i][2], vec[i][3]);
        excp_pc = 32'h8000_0000 + 32'(r * 16 + i);
        step();
      end
    end
    set_req(0, 0, 0, 0); excp_req = 0; mem_busy = 0;
    step(); step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central stall/flush controller for the 5-stage MIPS pipeline.
- Merges per-stage stall requests into a per-stage stall vector; ID/EX takes `stall[2]` as id_stall and `stall[3]` as ex_stall.
- Sequences exception flushes and defers a flush while a memory bus transaction cannot be abandoned.
- Counts stalled cycles for performance monitoring.

Parameters:
- ADDR_W, 32, width of flush target PC.
- CNT_W, 32, width of stall-cycle counter.
- WDOG_CYCLES, 1024, consecutive-stall limit for the watchdog (optional feature only).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- if_stallreq  in  1  IF stage requests stall
- id_stallreq  in  1  ID stage requests stall (load-use, branch operand wait)
- ex_stallreq  in  1  EX stage requests stall (multi-cycle mul/div)
- mem_stallreq  in  1  MEM stage requests stall (data bus wait)
- mem_busy  in  1  outstanding bus transaction that must complete before a flush
- excp_req  in  1  exception/ERET flush request; source holds it until excp_ack
- excp_pc  in  ADDR_W  handler/return PC, valid with excp_req
- stall  out  6  {wb,mem,ex,id,if,pc} hold bits
- flush  out  1  flush all pipeline registers
- flush_pc  out  ADDR_W  new PC, valid while flush=1
- excp_ack  out  1  exception accepted, one-cycle pulse
- stall_cycles  out  CNT_W  count of cycles with stall[0]=1
- stall_timeout  out  1  watchdog flag (0 when feature compiled out)

Behaviour:
- Stall vector, combinational in RUN, highest requester wins:
  - mem_stallreq → 6'b011111
  - else ex_stallreq → 6'b001111
  - else id_stallreq → 6'b000111
  - else if_stallreq → 6'b000011
  - else 6'b000000
- Bubble rule, implemented by the pipeline registers: the register after stage i loads a NOP when stall[i]=1 and stall[i+1]=0.
- FSM states RUN, PEND, FLUSH; reset state RUN.
- RUN:
  - excp_req=1 and mem_busy=0: capture excp_pc into flush_pc_r, go to FLUSH.
  - excp_req=1 and mem_busy=1: capture excp_pc, go to PEND.
  - Stall requests processed normally; excp_req has priority over stall requests for the state transition.
- PEND:
  - stall forced to 6'b011111 (WB drains).
  - Further excp_req changes ignored; captured PC retained.
  - mem_busy=0 → FLUSH.
- FLUSH (exactly one cycle):
  - flush=1, excp_ack=1, flush_pc=flush_pc_r, stall=6'b000000 regardless of requests.
  - Next state RUN.
- Latency: excp_req sampled high in RUN with mem_busy=0 → flush asserted on the following cycle (1-cycle latency). With mem_busy, flush follows the first cycle after mem_busy falls.
- Outside FLUSH: flush=0, excp_ack=0, flush_pc=flush_pc_r.
- stall_cycles:
  - +1 on every clock edge where stall[0]=1.
  - Wraps modulo 2^CNT_W.
  - Not cleared by flush.
- Reset mid-operation (any state): state→RUN, flush_pc_r=0, stall_cycles=0, stall_timeout=0, watchdog counter=0. Outputs at reset: stall=0, flush=0, excp_ack=0, flush_pc=0.
- Simultaneous stall request and excp_req in RUN: stall reflects requests this cycle; flush wins next cycle.

Optional Feature:
- Macro: PIPE_STALL_WDOG_EN.
- With the macro:
  - Internal counter increments on each consecutive cycle with stall[0]=1; clears on any cycle with stall[0]=0 or in FLUSH.
  - When the counter reaches WDOG_CYCLES, stall_timeout sets and stays sticky until rst.
  - Counter saturates at WDOG_CYCLES.
- Without the macro: no counter; stall_timeout tied to 0.

Decomposition:
- Shared package/defines header:
  - Stall-vector bit indices (STALL_PC..STALL_WB).
  - Constants STALL_NONE, STALL_IF, STALL_ID, STALL_EX, STALL_MEM.
  - FSM state encoding.
- Sub-module stall_wdog (counter + sticky flag), instantiated only under PIPE_STALL_WDOG_EN.

Test Plan:
- Reset with all requests high → stall=0, flush=0, stall_cycles=0. After release with ex_stallreq=1 only → stall=6'b001111, stall_cycles=1 after one edge.
- id_stallreq=1 and mem_stallreq=1 together → stall=6'b011111. Drop mem_stallreq → 6'b000111 same cycle.
- excp_req=1, excp_pc=0xBFC00380, mem_busy=0 in RUN → next cycle flush=1, excp_ack=1, flush_pc=0xBFC00380, stall=0. Following cycle flush=0.
- excp_req=1 with mem_busy=1 for 3 cycles, excp_pc changed to 0x0 after the first cycle → stall=6'b011111 for 3 cycles. Then flush=1 with flush_pc=0xBFC00380.
- Assert rst while in PEND → state RUN, all outputs 0. After release, excp_req=0 → no flush.
- PIPE_STALL_WDOG_EN, WDOG_CYCLES=8, if_stallreq held 8 cycles → stall_timeout=1 after the 8th edge, stays 1 after if_stallreq drops. A 7-cycle stall, then a gap, then 7 more → stall_timeout=0.
